// File: rtl/plc_pkg.sv
// Shared plant/controller definitions: FSM states, level thresholds, level clamp helper.
package plc_pkg;

  localparam int unsigned LVL_W = 8;   // level bus width
  localparam int unsigned SUM_W = 10;  // signed headroom for lvl +/- rate
  localparam int unsigned CNT_W = 8;   // overflow event counter width

  // Level thresholds shared with the level controller
  localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(20);
  localparam logic [LVL_W-1:0] LVL_MID  = LVL_W'(50);
  localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(90);

  typedef enum logic [1:0] {
    PS_NORMAL = 2'd0,
    PS_OVF    = 2'd1,
    PS_DRY    = 2'd2
  } plant_state_t;

  // Clamp a signed level sum into 0..lvl_max
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic signed [SUM_W-1:0] sum,
                                                  input logic [LVL_W-1:0]        lvl_max);
    logic [LVL_W-1:0] res;
    if (sum[SUM_W-1]) begin
      res = '0;
    end else if (sum > $signed(SUM_W'(lvl_max))) begin
      res = lvl_max;
    end else begin
      res = sum[LVL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running update prescaler: one-cycle tick every TICK_DIV un-frozen cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_freeze,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick_c  = w_at_last & ~i_freeze;

  // Count 0..TICK_DIV-1 and wrap; freeze holds the current count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_freeze) begin
      r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/water_tank_plant.sv
// Process-side tank model: integrates pump fill/drain per tick, saturates, flags overflow/dry-run.
module water_tank_plant
  import plc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned FILL_RATE  = 2,
  parameter int unsigned DRAIN_RATE = 3,
  parameter int unsigned LVL_MAX    = 100,
  parameter int unsigned OVF_LVL    = 95,
  parameter int unsigned INIT_LVL   = 0
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                pump1_ctrl,
  input  logic                pump2_ctrl,
  input  logic                freeze,
  output logic [LVL_W-1:0]    water_lvl,
  output logic                lvl_valid,
  output logic                overflow,
  output logic                dry_run,
  output logic [CNT_W-1:0]    ovf_count,
  output logic [1:0]          plant_state
);

  localparam logic signed [SUM_W-1:0] FILL_D    = SUM_W'(FILL_RATE);
  localparam logic signed [SUM_W-1:0] DRAIN_D   = SUM_W'(DRAIN_RATE);
  localparam logic signed [SUM_W-1:0] MAX_S     = SUM_W'(LVL_MAX);
  localparam logic [LVL_W-1:0]        LVL_MAX_V = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0]        OVF_LVL_V = LVL_W'(OVF_LVL);
  localparam logic [LVL_W-1:0]        INIT_V    = LVL_W'(INIT_LVL);
  localparam logic [CNT_W-1:0]        CNT_SAT   = '1;

  logic                    w_tick;
  logic signed [SUM_W-1:0] w_delta;
  logic signed [SUM_W-1:0] w_sum;
  logic [LVL_W-1:0]        w_next_lvl;
  logic                    w_over;
  logic                    w_under;

  logic [LVL_W-1:0]        r_water_lvl;
  logic                    r_lvl_valid;
  logic                    r_overflow;
  logic                    r_dry_run;
  logic [CNT_W-1:0]        r_ovf_count;
  plant_state_t            r_state;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .i_freeze (freeze),
    .o_tick_c (w_tick)
  );

  // Net per-tick change and the unclamped / clamped candidate level
  assign w_delta    = (pump1_ctrl ? FILL_D : SUM_W'(0)) - (pump2_ctrl ? DRAIN_D : SUM_W'(0));
  assign w_sum      = $signed(SUM_W'(r_water_lvl)) + w_delta;
  assign w_over     = (w_sum > MAX_S);
  assign w_under    = w_sum[SUM_W-1];
  assign w_next_lvl = clamp_lvl(w_sum, LVL_MAX_V);

  // Level integrator, plant FSM and overflow counter, all advanced on the tick
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_water_lvl <= INIT_V;
      r_lvl_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_dry_run   <= 1'b0;
      r_ovf_count <= '0;
      r_state     <= PS_NORMAL;
    end else begin
      r_lvl_valid <= w_tick;
      if (w_tick) begin
        r_water_lvl <= w_next_lvl;
        case (r_state)
          PS_NORMAL: begin
            if (w_over) begin
              r_state    <= PS_OVF;
              r_overflow <= 1'b1;
              r_dry_run  <= 1'b0;
              if (r_ovf_count != CNT_SAT) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
              end
            end else if (w_under && pump2_ctrl) begin
              r_state    <= PS_DRY;
              r_overflow <= 1'b0;
              r_dry_run  <= 1'b1;
            end else begin
              r_state    <= PS_NORMAL;
              r_overflow <= 1'b0;
              r_dry_run  <= 1'b0;
            end
          end
          PS_OVF: begin
            if (w_next_lvl < OVF_LVL_V) begin
              r_state    <= PS_NORMAL;
              r_overflow <= 1'b0;
            end else begin
              r_state    <= PS_OVF;
              r_overflow <= 1'b1;
            end
            r_dry_run <= 1'b0;
          end
          PS_DRY: begin
            if (!pump2_ctrl || (w_next_lvl != '0)) begin
              r_state   <= PS_NORMAL;
              r_dry_run <= 1'b0;
            end else begin
              r_state   <= PS_DRY;
              r_dry_run <= 1'b1;
            end
            r_overflow <= 1'b0;
          end
          default: begin
            r_state    <= PS_NORMAL;
            r_overflow <= 1'b0;
            r_dry_run  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign water_lvl   = r_water_lvl;
  assign lvl_valid   = r_lvl_valid;
  assign overflow    = r_overflow;
  assign dry_run     = r_dry_run;
  assign ovf_count   = r_ovf_count;
  assign plant_state = r_state;

endmodule

// File: tb/tb_water_tank_plant.sv
// Scoreboard bench for water_tank_plant: a tick-level tank model predicts each level update.
module tb_water_tank_plant;

  localparam int unsigned TICK_DIV = 4;
  localparam int FILL  = 2;
  localparam int DRAIN = 3;
  localparam int LMAX  = 100;
  localparam int OVFL  = 95;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       p1    = 1'b0;
  logic       p2    = 1'b0;
  logic       frz   = 1'b0;
  logic [7:0] water_lvl;
  logic       lvl_valid;
  logic       overflow;
  logic       dry_run;
  logic [7:0] ovf_count;
  logic [1:0] plant_state;

  always #5 clk = ~clk;

  water_tank_plant #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .pump1_ctrl  (p1),
    .pump2_ctrl  (p2),
    .freeze      (frz),
    .water_lvl   (water_lvl),
    .lvl_valid   (lvl_valid),
    .overflow    (overflow),
    .dry_run     (dry_run),
    .ovf_count   (ovf_count),
    .plant_state (plant_state)
  );

  typedef struct {
    int lvl;
    bit ovf;
    bit dry;
    int cnt;
    int st;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_shown;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Tank model state: level, mode (0 normal, 1 overflow, 2 dry), overflow count, cycles into period
  int m_lvl   = 0;
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_out(input string pfx, input exp_t e);
    check({pfx, "_lvl"},   32'(water_lvl),   32'(e.lvl));
    check({pfx, "_ovf"},   32'(overflow),    32'(e.ovf));
    check({pfx, "_dry"},   32'(dry_run),     32'(e.dry));
    check({pfx, "_cnt"},   32'(ovf_count),   32'(e.cnt));
    check({pfx, "_state"}, 32'(plant_state), 32'(e.st));
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.lvl = 0; e.ovf = 0; e.dry = 0; e.cnt = 0; e.st = 0; e.cyc = 0;
    return e;
  endfunction

  // One plant update from the tank's physical rules, pushed as the expected next publication
  task automatic model_tick(input bit a, input bit b);
    int   sum;
    int   nxt;
    exp_t e;
    sum = m_lvl + (a ? FILL : 0) - (b ? DRAIN : 0);
    nxt = (sum < 0) ? 0 : ((sum > LMAX) ? LMAX : sum);
    case (m_mode)
      0: begin
        if (sum > LMAX) begin
          m_mode = 1;
          if (m_cnt < 255) m_cnt++;
        end else if (sum < 0 && b) begin
          m_mode = 2;
        end
      end
      1: if (nxt < OVFL) m_mode = 0;
      2: if (!b || nxt > 0) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_lvl = nxt;
    e.lvl = m_lvl; e.ovf = (m_mode == 1); e.dry = (m_mode == 2);
    e.cnt = m_cnt; e.st = m_mode; e.cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Drive one clock cycle of inputs (called just after a rising edge)
  task automatic step(input bit a, input bit b, input bit f);
    p1 = a; p2 = b; frz = f;
    if (!f) begin
      if (m_phase == int'(TICK_DIV) - 1) begin
        model_tick(a, b);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_lvl",   32'(water_lvl),   32'd0);
    check("rst_valid", 32'(lvl_valid),   32'd0);
    check("rst_ovf",   32'(overflow),    32'd0);
    check("rst_dry",   32'(dry_run),     32'd0);
    check("rst_cnt",   32'(ovf_count),   32'd0);
    check("rst_state", 32'(plant_state), 32'd0);
    sb_q.delete();
    m_lvl = 0; m_mode = 0; m_cnt = 0; m_phase = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_ticks(input bit a, input bit b, input int ticks);
    repeat (ticks * int'(TICK_DIV)) step(a, b, 1'b0);
  endtask

  // Monitor: pop and compare on every published update, otherwise outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_shown = reset_exp();
    end else if (lvl_valid) begin
      check("valid_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
        check_out("upd", e);
        m_shown = e;
      end
    end else begin
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_valid: got 0 expected 1 (cycle %0d)", cyc);
        m_shown = e;
      end else begin
        check_out("hold", m_shown);
      end
    end
  end

  initial begin
    int guard;
    bit a, b;
    #2;
    do_reset(3);

    // Steady fill from empty up to 60, then reset two cycles into a period
    run_ticks(1'b1, 1'b0, 30);
    while (m_phase != 2) step(1'b1, 1'b0, 1'b0);
    do_reset(2);

    // Fill to exactly full (no overflow), one more tick overflows, then drain out of it
    run_ticks(1'b1, 1'b0, 51);
    run_ticks(1'b0, 1'b1, 2);
    // Drain down to empty and run dry, then stop the drain pump
    run_ticks(1'b0, 1'b1, 33);
    run_ticks(1'b0, 1'b0, 2);
    // Both pumps from 50
    run_ticks(1'b1, 1'b0, 25);
    run_ticks(1'b1, 1'b1, 3);
    // Freeze mid-period with fill requested
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b1);
    run_ticks(1'b1, 1'b0, 2);

    // Repeated overflow entries to push the counter into saturation
    for (int k = 0; k < 260; k++) begin
      guard = 0;
      while (m_mode != 0 && guard < 400) begin step(1'b0, 1'b1, 1'b0); guard++; end
      guard = 0;
      while (m_mode != 1 && guard < 400) begin step(1'b1, 1'b0, 1'b0); guard++; end
    end
    run_ticks(1'b0, 1'b1, 40);

    // Randomised segments: held patterns, per-cycle jitter, freeze bursts, occasional reset
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 1'($urandom_range(0, 1));
          b = 1'($urandom_range(0, 1));
          repeat ($urandom_range(4, 160)) step(a, b, 1'b0);
        end
        1: repeat ($urandom_range(4, 40))
             step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        2: repeat ($urandom_range(8, 40))
             step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
          else repeat ($urandom_range(4, 20)) step(1'b0, 1'b0, 1'b0);
        end
      endcase
    end

    step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
